// File: rtl/sys_ctrl_rx.sv
// Receive-side system controller: decodes UART command bytes into register-file
// and ALU strobes. Outputs are registered one cycle after the sampling edge.
module sys_ctrl_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  ALU_OUT_VLD,
  output logic [RF_ADDR-1:0]    Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S, ALU_WAIT
  } state_t;

  state_t             state;
  logic [RF_ADDR-1:0] wr_addr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      wr_addr     <= '0;
      Address     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
    end else begin
      WrEn   <= 1'b0;
      RdEn   <= 1'b0;
      ALU_EN <= 1'b0;
      case (state)
        IDLE: if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:     state <= WR_ADDR;
            CMD_RD:     state <= RD_ADDR;
            CMD_ALU_OP: state <= OP_A;
            CMD_ALU:    state <= ALU_FUN_S;
            default:    state <= IDLE;
          endcase
        end
        WR_ADDR: if (RX_D_VLD) begin
          wr_addr <= RX_P_DATA[RF_ADDR-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= wr_addr;
          WrData  <= RX_P_DATA;
          state   <= IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          RdEn    <= 1'b1;
          Address <= RX_P_DATA[RF_ADDR-1:0];
          state   <= IDLE;
        end
        // Operands land in the two lowest register-file slots the ALU reads from.
        OP_A: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= RF_ADDR'(0);
          WrData  <= RX_P_DATA;
          state   <= OP_B;
        end
        OP_B: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= RF_ADDR'(1);
          WrData  <= RX_P_DATA;
          state   <= ALU_FUN_S;
        end
        ALU_FUN_S: if (RX_D_VLD) begin
          ALU_EN      <= 1'b1;
          ALU_FUN     <= RX_P_DATA[3:0];
          CLK_GATE_EN <= 1'b1;
          state       <= ALU_WAIT;
        end
        // Clock gate stays open through the cycle the result is reported.
        ALU_WAIT: if (ALU_OUT_VLD) begin
          CLK_GATE_EN <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_ctrl_rx.md
SYS_CTRL_RX -- requirements
Module: sys_ctrl_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of UART bytes, register-file data and ALU operands.
REQ-002 Parameter RF_ADDR, default 4, SHALL set the register-file address width.
REQ-003 CLK  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 RX_P_DATA  in  DATA_WIDTH  SHALL carry the received UART byte, valid only while RX_D_VLD=1.
REQ-006 RX_D_VLD  in  1  SHALL be a one-cycle strobe per received byte.
REQ-007 ALU_OUT_VLD  in  1  SHALL indicate that the ALU result is ready.
REQ-008 Address  out  RF_ADDR  SHALL be the register-file address.
REQ-009 WrEn  out  1  SHALL be the register-file write strobe.
REQ-010 RdEn  out  1  SHALL be the register-file read strobe.
REQ-011 WrData  out  DATA_WIDTH  SHALL be the register-file write data.
REQ-012 ALU_EN  out  1  SHALL be the ALU start strobe.
REQ-013 ALU_FUN  out  4  SHALL be the ALU function select.
REQ-014 CLK_GATE_EN  out  1  SHALL enable the ALU clock gate.

Function
REQ-015 All outputs SHALL be registered; each output asserts in the cycle after the CLK edge that samples the enabling byte.
REQ-016 The FSM SHALL have the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S and ALU_WAIT; a state advances only on a cycle with RX_D_VLD=1, except ALU_WAIT.
REQ-017 In IDLE, command byte 0xAA SHALL go to WR_ADDR, 0xBB to RD_ADDR, 0xCC to OP_A and 0xDD to ALU_FUN_S; any other byte SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-018 In WR_ADDR, the byte SHALL be latched as RX_P_DATA[RF_ADDR-1:0] and the FSM SHALL go to WR_DATA; the upper bits SHALL be ignored.
REQ-019 In WR_DATA, the byte SHALL cause one cycle of WrEn=1 with Address equal to the latched address and WrData equal to the byte, and the FSM SHALL return to IDLE.
REQ-020 In RD_ADDR, the byte SHALL cause one cycle of RdEn=1 with Address=RX_P_DATA[RF_ADDR-1:0], and the FSM SHALL return to IDLE.
REQ-021 In OP_A, the byte SHALL be written (one-cycle WrEn) to address 0 and the FSM SHALL go to OP_B.
REQ-022 In OP_B, the byte SHALL be written to address 1 and the FSM SHALL go to ALU_FUN_S.
REQ-023 In ALU_FUN_S, the byte SHALL set ALU_FUN=RX_P_DATA[3:0] and cause one cycle of ALU_EN=1, and the FSM SHALL go to ALU_WAIT.
REQ-024 CLK_GATE_EN SHALL be 1 from the ALU_EN cycle through the cycle in which ALU_OUT_VLD=1 is sampled, then 0.
REQ-025 In ALU_WAIT, the FSM SHALL hold ALU_FUN and SHALL return to IDLE on the first cycle with ALU_OUT_VLD=1.
REQ-026 Bytes arriving in ALU_WAIT SHALL be dropped with no output effect.
REQ-027 ALU_OUT_VLD outside ALU_WAIT SHALL be ignored.
REQ-028 WrEn and RdEn SHALL never be 1 in the same cycle.
REQ-029 WrEn, RdEn and ALU_EN SHALL each be a single-cycle pulse per command and 0 otherwise.
REQ-030 Address, WrData and ALU_FUN SHALL hold their last value when no strobe is active.
REQ-031 Back-to-back bytes on consecutive cycles SHALL be accepted without loss in every state except ALU_WAIT.

Reset
REQ-032 While RST=0, the FSM SHALL be IDLE and all outputs and internal registers SHALL be 0, regardless of CLK.
REQ-033 A reset asserted mid-command SHALL abort that command: no strobe occurs and, after release, the next byte is decoded as a command.

Verification
REQ-034 Write then read: bytes 0xAA,0x05,0x3C -> one WrEn pulse with Address=5, WrData=0x3C; then 0xBB,0x05 -> one RdEn pulse with Address=5.
REQ-035 ALU with operands: bytes 0xCC,0x12,0x34,0x02 -> WrEn at address 0 with 0x12, WrEn at address 1 with 0x34, then ALU_EN pulse with ALU_FUN=2; CLK_GATE_EN stays 1 until ALU_OUT_VLD pulses, then 0 and the FSM returns to IDLE.
REQ-036 ALU without operands: bytes 0xDD,0x07 -> ALU_EN pulse with ALU_FUN=7 and no WrEn.
REQ-037 Drop behaviour: byte 0x55 in IDLE -> no strobes; byte 0xAA sent during ALU_WAIT -> ignored, and the next 0xBB,0x01 after ALU_OUT_VLD -> RdEn with Address=1.
REQ-038 Reset abort: 0xAA,0x03, then RST pulsed low, then 0x77 -> no WrEn and FSM in IDLE (0x77 discarded as an unknown command).
REQ-039 Address truncation: bytes 0xBB,0xF9 with RF_ADDR=4 -> RdEn with Address=9.
